vga_dtg: RTL and testbench
==========================

// Module: vga_dtg
// PURPOSE
//  Display timing generator: produces pixel coordinates, video_on and VGA syncs that feed
//  the pixel compositor and sprite/road generators. Runs on the system clock with an
//  internal pixel-rate enable. One position advances per pixel tick; frame_start marks frame origin.
// PARAMETERS
//  CLK_DIV     4    system clocks per pixel (100 MHz -> 25 MHz); must be >= 1
//  H_ACTIVE    640  visible columns
//  H_FP        16   horizontal front porch (pixels)
//  H_SYNC      96   horizontal sync width (pixels)
//  H_BP        48   horizontal back porch (pixels)
//  V_ACTIVE    480  visible rows
//  V_FP        10   vertical front porch (lines)
//  V_SYNC      2    vertical sync width (lines)
//  V_BP        33   vertical back porch (lines)
//  SYNC_POL    0    asserted sync level (0 = active-low)
//  SYNC_DELAY  2    sync pipeline depth in clk cycles (used only with VGA_SYNC_DELAY_EN)
// PORTS
//  clk          in   1   system clock
//  reset        in   1   asynchronous, active-high reset
//  pix_row      out  10  current vertical count (0..V_TOTAL-1)
//  pix_col      out  10  current horizontal count (0..H_TOTAL-1)
//  video_on     out  1   1 when pix_col<H_ACTIVE and pix_row<V_ACTIVE
//  horiz_sync   out  1   horizontal sync, level per SYNC_POL
//  vert_sync    out  1   vertical sync, level per SYNC_POL
//  pix_tick     out  1   1-clk pulse, last clk of each pixel period
//  frame_start  out  1   1-clk pulse on first clk of position (0,0)
// BEHAVIOUR
//  - H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525); both must be <=1024.
//  - Reset (async, any time incl. mid-line): div=0, hcount=vcount=0; pix_row=pix_col=0,
//    video_on=0, syncs at inactive level (~SYNC_POL), pix_tick=0, frame_start=0.
//  - Divider: div counts 0..CLK_DIV-1, wraps; pix_tick=1 when div==CLK_DIV-1. CLK_DIV=1 -> tick every clk.
//  - On pix_tick: hcount<=hcount+1; at hcount==H_TOTAL-1 hcount<=0 and vcount<=vcount+1;
//    at vcount==V_TOTAL-1 with line wrap, vcount<=0. No other wrap values permitted.
//  - All outputs registered; decoded from hcount/vcount, 1 clk latency. First clk after reset
//    release: pix_row=pix_col=0, video_on=1, frame_start=1. Each position held CLK_DIV clks.
//  - hsync asserted for hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (656..751).
//  - vsync asserted for vcount in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] (490..491), whole lines.
//  - In blanking pix_row/pix_col keep reporting raw counts; consumers gate with video_on.
//  - frame_start asserts once per frame only (not held for all CLK_DIV clks of (0,0)).
// CONFIGURATION
//  VGA_SYNC_DELAY_EN defined: horiz_sync/vert_sync pass through a SYNC_DELAY-stage shift
//    register (every clk) to align with compositor's 2-clk pixel latency; stages reset to
//    inactive level. pix_row/pix_col/video_on/frame_start unaffected.
//  Not defined: syncs edge-aligned with pix_col/pix_row; SYNC_DELAY ignored.
// TESTING
//  1 Release reset, defaults -> clk1: (row,col)=(0,0), video_on=1, frame_start=1; col=1 at clk5.
//  2 Run to col 639->640 -> video_on 1->0; col 799->0 with row 0->1 on same edge.
//  3 Line 0 -> horiz_sync low exactly 384 clks, starting first clk of col 656; high elsewhere.
//  4 Full frame -> vert_sync low for rows 490..491 (1600 pixels); frame_start period 1,680,000 clks.
//  5 Assert reset at (row100,col300) mid-period -> outputs 0/inactive same cycle, no clk needed.
//  6 VGA_SYNC_DELAY_EN, SYNC_DELAY=2 -> horiz_sync falls 2 clks after pix_col becomes 656.

Source files
------------

// File: rtl/vga_dtg.sv
// vga_dtg: VGA display timing generator with a pixel-rate enable, registered coordinates and syncs.
// Optional VGA_SYNC_DELAY_EN delays the syncs by SYNC_DELAY clocks so they line up with the compositor.
module vga_dtg #(
  parameter int CLK_DIV    = 4,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit SYNC_POL   = 1'b0,
  parameter int SYNC_DELAY = 2
) (
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] pix_row,
  output logic [9:0] pix_col,
  output logic       video_on,
  output logic       horiz_sync,
  output logic       vert_sync,
  output logic       pix_tick,
  output logic       frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [9:0] HS_LO = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_HI = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_LO = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_HI = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  logic [DW-1:0] div_q, div_d;
  logic [9:0] h_q, h_d, v_q, v_d;
  logic [9:0] pix_row_q, pix_row_d, pix_col_q, pix_col_d;
  logic video_on_q, video_on_d, hs_q, hs_d, vs_q, vs_d;
  logic pix_tick_q, pix_tick_d, frame_start_q, frame_start_d;
  logic tick, h_end;
  always_comb begin
    tick = div_q == DW'(CLK_DIV - 1);
    h_end = h_q == 10'(H_TOTAL - 1);
    div_d = tick ? '0 : div_q + 1'b1;
    h_d = !tick ? h_q : h_end ? '0 : h_q + 1'b1;
    v_d = !(tick && h_end) ? v_q : (v_q == 10'(V_TOTAL - 1)) ? '0 : v_q + 1'b1;
    pix_row_d = v_q;
    pix_col_d = h_q;
    video_on_d = h_q < 10'(H_ACTIVE) && v_q < 10'(V_ACTIVE);
    hs_d = (h_q >= HS_LO && h_q <= HS_HI) ? SYNC_POL : ~SYNC_POL;
    vs_d = (v_q >= VS_LO && v_q <= VS_HI) ? SYNC_POL : ~SYNC_POL;
    pix_tick_d = tick;
    // first clk of (0,0) only, so the pulse is one clk wide regardless of CLK_DIV
    frame_start_d = h_q == '0 && v_q == '0 && div_q == '0;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q <= '0;
      h_q <= '0;
      v_q <= '0;
      pix_row_q <= '0;
      pix_col_q <= '0;
      video_on_q <= 1'b0;
      hs_q <= ~SYNC_POL;
      vs_q <= ~SYNC_POL;
      pix_tick_q <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q <= div_d;
      h_q <= h_d;
      v_q <= v_d;
      pix_row_q <= pix_row_d;
      pix_col_q <= pix_col_d;
      video_on_q <= video_on_d;
      hs_q <= hs_d;
      vs_q <= vs_d;
      pix_tick_q <= pix_tick_d;
      frame_start_q <= frame_start_d;
    end
  end
`ifdef VGA_SYNC_DELAY_EN
  logic [SYNC_DELAY-1:0] hs_sr_q, hs_sr_d, vs_sr_q, vs_sr_d;
  always_comb begin
    hs_sr_d = SYNC_DELAY'({hs_sr_q, hs_q});
    vs_sr_d = SYNC_DELAY'({vs_sr_q, vs_q});
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_sr_q <= {SYNC_DELAY{~SYNC_POL}};
      vs_sr_q <= {SYNC_DELAY{~SYNC_POL}};
    end else begin
      hs_sr_q <= hs_sr_d;
      vs_sr_q <= vs_sr_d;
    end
  end
  assign horiz_sync = hs_sr_q[SYNC_DELAY-1];
  assign vert_sync = vs_sr_q[SYNC_DELAY-1];
`else
  assign horiz_sync = hs_q;
  assign vert_sync = vs_q;
`endif
  assign pix_row = pix_row_q;
  assign pix_col = pix_col_q;
  assign video_on = video_on_q;
  assign pix_tick = pix_tick_q;
  assign frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_dtg.sv
// tb_vga_dtg: checks a small-geometry vga_dtg (CLK_DIV 4 and 1) against a closed-form timing model.
module tb_vga_dtg;
  localparam int HA = 8, HF = 2, HS = 3, HB = 3, VA = 4, VF = 1, VS = 2, VB = 1, SD = 2;
  localparam int HT = HA + HF + HS + HB, VT = VA + VF + VS + VB;
  logic clk = 1'b0, reset = 1'b1;
  logic [9:0] row4, col4, row1, col1;
  logic von4, hs4, vs4, tk4, fs4, von1, hs1, vs1, tk1, fs1;
  int n_cmp = 0, n_err = 0;
  logic [24:0] q4[$], q1[$];
  typedef struct {
    int k;
    int row, col;
    logic von, hs, vs, tick, fs;
  } vec_t;
  vec_t tbl[16];
  always #5 clk = ~clk;
  vga_dtg #(.CLK_DIV(4), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB), .V_ACTIVE(VA),
    .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b0), .SYNC_DELAY(SD)) u4 (
    .clk(clk), .reset(reset), .pix_row(row4), .pix_col(col4), .video_on(von4),
    .horiz_sync(hs4), .vert_sync(vs4), .pix_tick(tk4), .frame_start(fs4));
  vga_dtg #(.CLK_DIV(1), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB), .V_ACTIVE(VA),
    .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b0), .SYNC_DELAY(SD)) u1 (
    .clk(clk), .reset(reset), .pix_row(row1), .pix_col(col1), .video_on(von1),
    .horiz_sync(hs1), .vert_sync(vs1), .pix_tick(tk1), .frame_start(fs1));
  // k = clk edges since reset release; outputs after edge k describe the (k-1)th clk of the raster
  function automatic logic [24:0] model(int cd, int k);
    int p, s, ps, hc, hr;
    logic von, hs, vs, tick, fs;
    if (k < 1) return {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    p = (k - 1) / cd;
    s = (k - 1) % cd;
    von = (p % HT) < HA && ((p / HT) % VT) < VA;
    tick = s == cd - 1;
    fs = (p % (HT * VT)) == 0 && s == 0;
`ifdef VGA_SYNC_DELAY_EN
    ps = k - SD;
`else
    ps = k;
`endif
    hs = 1'b1;
    vs = 1'b1;
    if (ps >= 1) begin
      hc = ((ps - 1) / cd) % HT;
      hr = (((ps - 1) / cd) / HT) % VT;
      hs = !(hc >= HA + HF && hc < HA + HF + HS);
      vs = !(hr >= VA + VF && hr < VA + VF + VS);
    end
    return {10'((p / HT) % VT), 10'(p % HT), von, hs, vs, tick, fs};
  endfunction
  task automatic chk(string name, int k, logic [24:0] act, logic [24:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s k=%0d: got row=%0d col=%0d von/hs/vs/tick/fs=%b, want row=%0d col=%0d von/hs/vs/tick/fs=%b",
        name, k, act[24:15], act[14:5], act[4:0], exp[24:15], exp[14:5], exp[4:0]);
    end
  endtask
  task automatic run(int n);
    int ti = 0;
    for (int k = 1; k <= n; k++) begin
      q4.push_back(model(4, k));
      q1.push_back(model(1, k));
      @(posedge clk);
      @(negedge clk);
      chk("div4", k, {row4, col4, von4, hs4, vs4, tk4, fs4}, q4.pop_front());
      chk("div1", k, {row1, col1, von1, hs1, vs1, tk1, fs1}, q1.pop_front());
      if (ti < 16 && tbl[ti].k == k) begin
        chk("tbl", k, {2'b0, row4, col4, von4, tk4, fs4},
          {2'b0, 10'(tbl[ti].row), 10'(tbl[ti].col), tbl[ti].von, tbl[ti].tick, tbl[ti].fs});
`ifndef VGA_SYNC_DELAY_EN
        chk("tbl_sync", k, {23'd0, hs4, vs4}, {23'd0, tbl[ti].hs, tbl[ti].vs});
`endif
        ti++;
      end
    end
  endtask
  initial begin
    tbl[0]  = '{1, 0, 0, 1, 1, 1, 0, 1};
    tbl[1]  = '{4, 0, 0, 1, 1, 1, 1, 0};
    tbl[2]  = '{5, 0, 1, 1, 1, 1, 0, 0};
    tbl[3]  = '{32, 0, 7, 1, 1, 1, 1, 0};
    tbl[4]  = '{33, 0, 8, 0, 1, 1, 0, 0};
    tbl[5]  = '{41, 0, 10, 0, 0, 1, 0, 0};
    tbl[6]  = '{52, 0, 12, 0, 0, 1, 1, 0};
    tbl[7]  = '{53, 0, 13, 0, 1, 1, 0, 0};
    tbl[8]  = '{64, 0, 15, 0, 1, 1, 1, 0};
    tbl[9]  = '{65, 1, 0, 1, 1, 1, 0, 0};
    tbl[10] = '{257, 4, 0, 0, 1, 1, 0, 0};
    tbl[11] = '{321, 5, 0, 0, 1, 0, 0, 0};
    tbl[12] = '{445, 6, 15, 0, 1, 0, 0, 0};
    tbl[13] = '{449, 7, 0, 0, 1, 1, 0, 0};
    tbl[14] = '{513, 0, 0, 1, 1, 1, 0, 1};
    tbl[15] = '{514, 0, 0, 1, 1, 1, 0, 0};
    repeat (3) @(negedge clk);
    chk("reset4", 0, {row4, col4, von4, hs4, vs4, tk4, fs4}, model(4, 0));
    chk("reset1", 0, {row1, col1, von1, hs1, vs1, tk1, fs1}, model(1, 0));
    reset = 1'b0;
    run(600);
    // asynchronous reset mid pixel period, checked before any further clk edge
    #2 reset = 1'b1;
    #1;
    chk("async_rst4", 0, {row4, col4, von4, hs4, vs4, tk4, fs4}, model(4, 0));
    chk("async_rst1", 0, {row1, col1, von1, hs1, vs1, tk1, fs1}, model(1, 0));
    @(negedge clk);
    chk("held_rst4", 0, {row4, col4, von4, hs4, vs4, tk4, fs4}, model(4, 0));
    reset = 1'b0;
    run(80);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
